// File: rtl/keypad_unit_pkg.sv
// keypad_unit_pkg
//   Shared definitions for the keypad responder: key codes, scanner state
//   encodings, the keypad MMIO address, key classification helpers.
//   Optional feature macro used by importers: KEYPAD_NEGATIVE_EN.
package keypad_unit_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_0     = 4'h0;
  localparam key_code_t KEY_1     = 4'h1;
  localparam key_code_t KEY_2     = 4'h2;
  localparam key_code_t KEY_3     = 4'h3;
  localparam key_code_t KEY_4     = 4'h4;
  localparam key_code_t KEY_5     = 4'h5;
  localparam key_code_t KEY_6     = 4'h6;
  localparam key_code_t KEY_7     = 4'h7;
  localparam key_code_t KEY_8     = 4'h8;
  localparam key_code_t KEY_9     = 4'h9;
  localparam key_code_t KEY_A     = 4'hA;
  localparam key_code_t KEY_B     = 4'hB;
  localparam key_code_t KEY_C     = 4'hC;
  localparam key_code_t KEY_D     = 4'hD;
  localparam key_code_t KEY_STAR  = 4'hE;
  localparam key_code_t KEY_POUND = 4'hF;

  // Scanner states (plain encodings so older Verilog users can share them)
  localparam logic [1:0] KP_SCAN     = 2'd0;
  localparam logic [1:0] KP_PRESS_DB = 2'd1;
  localparam logic [1:0] KP_HELD     = 2'd2;
  localparam logic [1:0] KP_REL_DB   = 2'd3;

  // Word address data_mem decodes as the keypad input register
  localparam logic [31:0] KEYPAD_ADDR = 32'hFFFF_FC10;

  typedef enum logic [2:0] {
    KCLASS_DIGIT,
    KCLASS_CLEAR,
    KCLASS_ENTER,
    KCLASS_PAUSE,
    KCLASS_SIGN,
    KCLASS_NONE
  } key_class_t;

  // Physical position -> key code
  function automatic key_code_t key_lookup(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_POUND;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

  // Lowest-index active-low column; only meaningful when some column is low
  function automatic logic [1:0] lowest_low(input logic [3:0] col);
    logic [1:0] idx;
    if (!col[0])      idx = 2'd0;
    else if (!col[1]) idx = 2'd1;
    else if (!col[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

  function automatic key_class_t classify(input key_code_t code);
    key_class_t cls;
    if (code <= KEY_9)          cls = KCLASS_DIGIT;
    else if (code == KEY_B)     cls = KCLASS_CLEAR;
    else if (code == KEY_D)     cls = KCLASS_ENTER;
    else if (code == KEY_C)     cls = KCLASS_PAUSE;
    else if (code == KEY_STAR)  cls = KCLASS_SIGN;
    else                        cls = KCLASS_NONE;
    return cls;
  endfunction

endpackage

// File: rtl/keypad_unit_if.sv
// keypad_unit_if
//   Keypad read handshake and status bus between the CPU side (master:
//   data_mem / hazard unit / vga_unit) and the keypad unit (slave).
//   keypad_read_enable   master->slave  keypad load pending
//   keypad_read_complete slave->master  operand valid (level)
//   keypad_data          slave->master  completed operand
//   cpu_pause            slave->master  one-cycle pause request
//   cpu_resume           slave->master  resume request (level)
//   input_value          slave->master  operand being typed
//   digit_count          slave->master  digits typed so far
interface keypad_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  keypad_read_enable;
  logic                  keypad_read_complete;
  logic [DATA_WIDTH-1:0] keypad_data;
  logic                  cpu_pause;
  logic                  cpu_resume;
  logic [DATA_WIDTH-1:0] input_value;
  logic [3:0]            digit_count;

  modport master (
    output keypad_read_enable,
    input  keypad_read_complete, keypad_data, cpu_pause, cpu_resume,
           input_value, digit_count
  );

  modport slave (
    input  keypad_read_enable,
    output keypad_read_complete, keypad_data, cpu_pause, cpu_resume,
           input_value, digit_count
  );
endinterface

// File: rtl/keypad_unit_scanner.sv
// keypad_unit_scanner
//   Drives keypad rows one at a time, debounces press and release, and emits
//   a one-cycle key_valid with the decoded key_code per accepted press.
//   Ports: clk, rst (async, active high), col_in[3:0] (active low),
//          row_out[3:0] (one-hot active low), key_valid, key_code[3:0].
module keypad_unit_scanner
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 200000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic      key_valid,
  output key_code_t key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT);

  logic [1:0]       state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic             valid_q, valid_d;
  key_code_t        code_q, code_d;
  logic [3:0]       row_out_q;

  logic       any_low;
  logic [1:0] low_idx;

  assign any_low = ~&col_in;
  assign low_idx = lowest_low(col_in);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    div_d   = div_q;
    db_d    = db_q;
    valid_d = 1'b0;
    code_d  = code_q;
    case (state_q)
      KP_SCAN: begin
        if (any_low) begin
          // Freeze on this row; the lowest low column is the candidate key
          state_d = KP_PRESS_DB;
          col_d   = low_idx;
          db_d    = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          row_d = row_q + 2'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      KP_PRESS_DB: begin
        if (!any_low || low_idx != col_q) begin
          state_d = KP_SCAN;
          div_d   = '0;
        end else if (db_q == DB_LAST) begin
          valid_d = 1'b1;
          code_d  = key_lookup(row_q, col_q);
          state_d = KP_HELD;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      KP_HELD: begin
        if (!any_low) begin
          state_d = KP_REL_DB;
          db_d    = '0;
        end
      end
      default: begin // KP_REL_DB
        if (any_low) begin
          state_d = KP_HELD;
        end else if (db_q == DB_LAST) begin
          state_d = KP_SCAN;
          div_d   = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= KP_SCAN;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      div_q     <= '0;
      db_q      <= '0;
      valid_q   <= 1'b0;
      code_q    <= KEY_0;
      row_out_q <= 4'b1110;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      div_q     <= div_d;
      db_q      <= db_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      row_out_q <= ~(4'b0001 << row_d);
    end
  end

  assign row_out   = row_out_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: rtl/keypad_unit.sv
// keypad_unit
//   Keypad responder: scans/debounces a 4x4 keypad and converts key events
//   into a decimal operand, the keypad read handshake and pause/resume
//   requests for the hazard unit.
//   Ports: clk, rst (async, active high), row_out[3:0], col_in[3:0],
//          kp (keypad_unit_if.slave: read enable/complete, data, pause,
//          resume, live value, digit count).
//   Optional feature: define KEYPAD_NEGATIVE_EN to let '*' toggle a sign
//   flag; Enter then returns the two's complement of the typed value.
module keypad_unit
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 200000,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_DIGITS   = 9
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  keypad_unit_if.slave kp
);

  logic      key_valid;
  key_code_t key_code;

  keypad_unit_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            count_q, count_d;
  logic                  complete_q, complete_d;
  logic                  paused_q, paused_d;
  logic                  pause_q, pause_d;
  logic                  resume_q, resume_d;
`ifdef KEYPAD_NEGATIVE_EN
  logic                  neg_q, neg_d;
`endif

  logic       rd_active;
  key_class_t key_cls;

  assign rd_active = kp.keypad_read_enable & ~complete_q;
  assign key_cls   = classify(key_code);

  always_comb begin
    value_d    = value_q;
    data_d     = data_q;
    count_d    = count_q;
    complete_d = complete_q;
    paused_d   = paused_q;
    pause_d    = 1'b0;
    resume_d   = resume_q;
`ifdef KEYPAD_NEGATIVE_EN
    neg_d      = neg_q;
`endif

    // Enable low dominates: it ends a completed read and flushes an
    // unfinished one, even if Enter arrives in the same cycle.
    if (!kp.keypad_read_enable) begin
      complete_d = 1'b0;
      value_d    = '0;
      count_d    = 4'd0;
`ifdef KEYPAD_NEGATIVE_EN
      neg_d      = 1'b0;
`endif
    end else if (key_valid && rd_active) begin
      case (key_cls)
        KCLASS_DIGIT: begin
          if (count_q < 4'(MAX_DIGITS)) begin
            value_d = value_q * DATA_WIDTH'(10) + {{(DATA_WIDTH-4){1'b0}}, key_code};
            count_d = count_q + 4'd1;
          end
        end
        KCLASS_CLEAR: begin
          value_d = '0;
          count_d = 4'd0;
`ifdef KEYPAD_NEGATIVE_EN
          neg_d   = 1'b0;
`endif
        end
        KCLASS_ENTER: begin
`ifdef KEYPAD_NEGATIVE_EN
          data_d  = neg_q ? (DATA_WIDTH'(0) - value_q) : value_q;
          neg_d   = 1'b0;
`else
          data_d  = value_q;
`endif
          complete_d = 1'b1;
          value_d    = '0;
          count_d    = 4'd0;
        end
`ifdef KEYPAD_NEGATIVE_EN
        KCLASS_SIGN: neg_d = ~neg_q;
`endif
        default: ;
      endcase
    end

    // Pause/resume works regardless of any keypad read in progress
    if (key_valid && key_cls == KCLASS_PAUSE) begin
      if (paused_q) begin
        paused_d = 1'b0;
        resume_d = 1'b1;
      end else begin
        paused_d = 1'b1;
        pause_d  = 1'b1;
        resume_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      data_q     <= '0;
      count_q    <= 4'd0;
      complete_q <= 1'b0;
      paused_q   <= 1'b0;
      pause_q    <= 1'b0;
      resume_q   <= 1'b0;
`ifdef KEYPAD_NEGATIVE_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      value_q    <= value_d;
      data_q     <= data_d;
      count_q    <= count_d;
      complete_q <= complete_d;
      paused_q   <= paused_d;
      pause_q    <= pause_d;
      resume_q   <= resume_d;
`ifdef KEYPAD_NEGATIVE_EN
      neg_q      <= neg_d;
`endif
    end
  end

  assign kp.keypad_read_complete = complete_q;
  assign kp.keypad_data          = data_q;
  assign kp.cpu_pause            = pause_q;
  assign kp.cpu_resume           = resume_q;
  assign kp.input_value          = value_q;
  assign kp.digit_count          = count_q;

endmodule

// File: tb/tb_keypad_unit.sv
// tb_keypad_unit
//   Directed keypad scenarios with a scoreboard: expected output events are
//   queued as keys are pressed; a negedge monitor pops and compares whenever
//   the DUT's outputs change.
module tb_keypad_unit;

  localparam int EV_DIGIT    = 0;  // a = input_value, b = digit_count
  localparam int EV_COMPLETE = 1;  // a = keypad_data
  localparam int EV_CFALL    = 2;  // a = input_value, b = digit_count
  localparam int EV_PAUSE    = 3;  // a = cpu_resume at the pulse
  localparam int EV_RESUME   = 4;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [3:0]  b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_out;
  logic [3:0] col_in;

  keypad_unit_if #(.DATA_WIDTH(32)) kif ();

  keypad_unit #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8),
    .DATA_WIDTH   (32),
    .MAX_DIGITS   (9)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_out (row_out),
    .col_in  (col_in),
    .kp      (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: a held key pulls its column low while its row is driven
  logic       key_down  = 1'b0;
  logic       bounce_hi = 1'b0;
  logic [1:0] k_row = 2'd0;
  logic [1:0] k_col = 2'd0;

  always_comb begin
    col_in = 4'hF;
    if (key_down && !bounce_hi && row_out[k_row] == 1'b0)
      col_in[k_col] = 1'b0;
  end

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  task automatic expect_ev(input int kind, input logic [31:0] a, input logic [3:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic handle(input int kind, input logic [31:0] a, input logic [3:0] b, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event a=0x%0h b=%0d, required no event", nm, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        errors++;
        $display("FAIL %s: got kind=%0d a=0x%0h b=%0d, required kind=%0d a=0x%0h b=%0d",
                 nm, kind, a, b, e.kind, e.a, e.b);
      end else begin
        $display("ok   %s a=0x%0h b=%0d", nm, a, b);
      end
    end
  endtask

  // Monitor
  logic [31:0] prev_iv = '0;
  logic [3:0]  prev_dc = '0;
  logic        prev_c  = 1'b0;
  logic        prev_r  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (kif.input_value != prev_iv || kif.digit_count != prev_dc)
        handle(EV_DIGIT, kif.input_value, kif.digit_count, "digit");
      if (kif.keypad_read_complete && !prev_c)
        handle(EV_COMPLETE, kif.keypad_data, 4'd0, "complete");
      if (!kif.keypad_read_complete && prev_c)
        handle(EV_CFALL, kif.input_value, kif.digit_count, "complete_fall");
      if (kif.cpu_pause)
        handle(EV_PAUSE, {31'd0, kif.cpu_resume}, 4'd0, "pause");
      if (kif.cpu_resume && !prev_r)
        handle(EV_RESUME, 32'd0, 4'd0, "resume");
    end
    prev_iv = kif.input_value;
    prev_dc = kif.digit_count;
    prev_c  = kif.keypad_read_complete;
    prev_r  = kif.cpu_resume;
  end

  task automatic direct(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end else begin
      $display("ok   %s = 0x%0h", nm, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    k_row    = r;
    k_col    = c;
    key_down = 1'b1;
    cycles(40);
    key_down = 1'b0;
    cycles(25);
  endtask

  task automatic wait_row0();
    int n;
    n = 0;
    while (row_out != 4'b1110 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (row_out != 4'b1110) begin
      errors++;
      $display("FAIL row0_wait: row_out=%b, required 1110 within 64 cycles", row_out);
    end
  endtask

  task automatic check_reset_state(input string tag);
    direct({tag, "_row_out"},  {28'd0, row_out}, 32'h0000_000E);
    direct({tag, "_complete"}, {31'd0, kif.keypad_read_complete}, 32'd0);
    direct({tag, "_data"},     kif.keypad_data, 32'd0);
    direct({tag, "_pause"},    {31'd0, kif.cpu_pause}, 32'd0);
    direct({tag, "_resume"},   {31'd0, kif.cpu_resume}, 32'd0);
    direct({tag, "_value"},    kif.input_value, 32'd0);
    direct({tag, "_count"},    {28'd0, kif.digit_count}, 32'd0);
  endtask

  logic [31:0] nines [9] = '{32'd9, 32'd99, 32'd999, 32'd9999, 32'd99999,
                             32'd999999, 32'd9999999, 32'd99999999, 32'd999999999};

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 30000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    kif.keypad_read_enable = 1'b0;
    cycles(3);
    check_reset_state("reset");
    rst = 1'b0;
    cycles(2);

    // Held key yields one digit; re-press appends
    kif.keypad_read_enable = 1'b1;
    expect_ev(EV_DIGIT, 32'd5, 4'd1);
    press(2'd1, 2'd1);
    expect_ev(EV_DIGIT, 32'd55, 4'd2);
    press(2'd1, 2'd1);

    // B clears, then 1,2,3,D
    expect_ev(EV_DIGIT, 32'd0, 4'd0);
    press(2'd1, 2'd3);
    expect_ev(EV_DIGIT, 32'd1, 4'd1);
    press(2'd0, 2'd0);
    expect_ev(EV_DIGIT, 32'd12, 4'd2);
    press(2'd0, 2'd1);
    expect_ev(EV_DIGIT, 32'd123, 4'd3);
    press(2'd0, 2'd2);
    expect_ev(EV_DIGIT, 32'd0, 4'd0);
    expect_ev(EV_COMPLETE, 32'd123, 4'd0);
    press(2'd3, 2'd3);
    press(2'd1, 2'd0);            // digit while complete is high: ignored
    expect_ev(EV_CFALL, 32'd0, 4'd0);
    kif.keypad_read_enable = 1'b0;
    cycles(3);

    // C three times: pause, resume, pause
    expect_ev(EV_PAUSE, 32'd0, 4'd0);
    press(2'd2, 2'd3);
    expect_ev(EV_RESUME, 32'd0, 4'd0);
    press(2'd2, 2'd3);
    expect_ev(EV_PAUSE, 32'd0, 4'd0);
    press(2'd2, 2'd3);

    // Ten 9s: the tenth is dropped
    kif.keypad_read_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expect_ev(EV_DIGIT, nines[i], 4'(i + 1));
      press(2'd2, 2'd2);
    end
    expect_ev(EV_DIGIT, 32'd0, 4'd0);
    expect_ev(EV_COMPLETE, 32'd999999999, 4'd0);
    press(2'd3, 2'd3);
    expect_ev(EV_CFALL, 32'd0, 4'd0);
    kif.keypad_read_enable = 1'b0;
    cycles(3);

    // Aborted read; A and # ignored; keypad_data held
    kif.keypad_read_enable = 1'b1;
    expect_ev(EV_DIGIT, 32'd7, 4'd1);
    press(2'd2, 2'd0);
    press(2'd0, 2'd3);
    press(2'd3, 2'd2);
    expect_ev(EV_DIGIT, 32'd0, 4'd0);
    kif.keypad_read_enable = 1'b0;
    cycles(3);
    direct("abort_data_held", kif.keypad_data, 32'd999999999);
    direct("abort_complete",  {31'd0, kif.keypad_read_complete}, 32'd0);

    // C during a read resumes without touching the operand
    kif.keypad_read_enable = 1'b1;
    expect_ev(EV_DIGIT, 32'd3, 4'd1);
    press(2'd0, 2'd2);
    expect_ev(EV_RESUME, 32'd0, 4'd0);
    press(2'd2, 2'd3);
    expect_ev(EV_DIGIT, 32'd0, 4'd0);
    expect_ev(EV_COMPLETE, 32'd3, 4'd0);
    press(2'd3, 2'd3);
    expect_ev(EV_CFALL, 32'd0, 4'd0);
    kif.keypad_read_enable = 1'b0;
    cycles(3);

    // Bouncing contact on key 1 gives a single press
    kif.keypad_read_enable = 1'b1;
    expect_ev(EV_DIGIT, 32'd1, 4'd1);
    k_row = 2'd0;
    k_col = 2'd0;
    wait_row0();
    key_down = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bounce_hi = i[0];
      @(negedge clk);
    end
    bounce_hi = 1'b0;
    cycles(40);
    key_down = 1'b0;
    cycles(25);

    // Reset during press debounce; held key is re-detected afterwards
    k_row = 2'd0;
    k_col = 2'd1;
    wait_row0();
    key_down = 1'b1;
    cycles(3);
    #3 rst = 1'b1;
    #1 check_reset_state("midreset");
    cycles(2);
    expect_ev(EV_DIGIT, 32'd2, 4'd1);
    #3 rst = 1'b0;
    cycles(40);
    key_down = 1'b0;
    cycles(25);
    expect_ev(EV_DIGIT, 32'd0, 4'd0);
    kif.keypad_read_enable = 1'b0;
    cycles(3);

    // 7, *, D
    kif.keypad_read_enable = 1'b1;
    expect_ev(EV_DIGIT, 32'd7, 4'd1);
    press(2'd2, 2'd0);
    press(2'd3, 2'd0);
    expect_ev(EV_DIGIT, 32'd0, 4'd0);
`ifdef KEYPAD_NEGATIVE_EN
    expect_ev(EV_COMPLETE, 32'hFFFF_FFF9, 4'd0);
`else
    expect_ev(EV_COMPLETE, 32'd7, 4'd0);
`endif
    press(2'd3, 2'd3);
    expect_ev(EV_CFALL, 32'd0, 4'd0);
    kif.keypad_read_enable = 1'b0;

    // Drain the scoreboard
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
